// File: rtl/cla_pkg.sv
// Shared constants for the two-level carry-lookahead adder.
package cla_pkg;
    localparam int unsigned CLA_WIDTH = 16;
    localparam int unsigned CLA_GROUP = 4;
endpackage

// File: rtl/cla_if.sv
// Operand/result bundle between the operand source and the adder.
interface cla_if #(
    parameter int unsigned WIDTH = cla_pkg::CLA_WIDTH
) ();
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output a, output b, output cin, input sum, input cout);
    modport slave  (input a, input b, input cin, output sum, output cout);
endinterface

// File: rtl/cla4.sv
// 4-bit carry-lookahead block: fully expanded internal carries plus group G/P.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       G,
    output logic       P
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Each carry built directly from g/p and c_in, no chaining through w_c.
    assign w_c[0] = c_in;
    assign w_c[1] = w_g[0] | (w_p[0] & c_in);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c_in);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & c_in);

    assign s = w_p ^ w_c;
    assign G = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign P = &w_p;
endmodule

// File: rtl/cla.sv
// Registered WIDTH-bit adder: cla4 groups joined by a second-level lookahead.
module cla
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = CLA_WIDTH
) (
    input  logic  clk,
    input  logic  rst_n,
    cla_if.slave  bus
);
    localparam int unsigned NG = WIDTH / CLA_GROUP;

    logic [NG-1:0]    w_grp_g;
    logic [NG-1:0]    w_grp_p;
    logic [NG:0]      w_grp_c;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    // Carry into group k as a flat sum of products over group G/P and cin.
    function automatic logic f_carry(input logic [NG-1:0] gg, input logic [NG-1:0] pp,
                                     input logic c0, input int k);
        logic acc;
        logic t;
        acc = c0;
        for (int j = 0; j < k; j++) acc = acc & pp[j];
        for (int j = 0; j < k; j++) begin
            t = gg[j];
            for (int m = j + 1; m < k; m++) t = t & pp[m];
            acc = acc | t;
        end
        return acc;
    endfunction

    assign w_grp_c[0] = bus.cin;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla4 u_cla4 (
            .a    (bus.a[CLA_GROUP*k +: CLA_GROUP]),
            .b    (bus.b[CLA_GROUP*k +: CLA_GROUP]),
            .c_in (w_grp_c[k]),
            .s    (w_sum[CLA_GROUP*k +: CLA_GROUP]),
            .G    (w_grp_g[k]),
            .P    (w_grp_p[k])
        );
        assign w_grp_c[k+1] = f_carry(w_grp_g, w_grp_p, bus.cin, k + 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_grp_c[NG];
        end
    end

    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule

// File: tb/tb_cla.sv
// Scoreboard bench for cla: driver queues expected {cout,sum}, monitor checks one edge later.
module tb_cla;
    localparam int W = 16;

    logic clk;
    logic rst_n;
    cla_if #(.WIDTH(W)) bus ();

    cla #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W:0] exp_q[$];
    int         id_q[$];
    int         checks = 0;
    int         errors = 0;
    int         next_id = 0;

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic [W:0] exp_v);
        @(negedge clk);
        bus.a   = a;
        bus.b   = b;
        bus.cin = c;
        exp_q.push_back(exp_v);
        id_q.push_back(next_id);
        next_id++;
    endtask

    task automatic check_now(input string name, input logic [W:0] exp_v);
        checks++;
        if ({bus.cout, bus.sum} !== exp_v) begin
            errors++;
            $display("FAIL %s: got cout=%0b sum=%0h, want cout=%0b sum=%0h",
                     name, bus.cout, bus.sum, exp_v[W], exp_v[W-1:0]);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, want 0", exp_q.size());
            exp_q.delete();
            id_q.delete();
        end
    endtask

    // Monitor: one result per rising edge while out of reset.
    initial begin
        logic [W:0] e;
        int         id;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                id = id_q.pop_front();
                checks++;
                if ({bus.cout, bus.sum} !== e) begin
                    errors++;
                    $display("FAIL vec%0d: got cout=%0b sum=%0h, want cout=%0b sum=%0h",
                             id, bus.cout, bus.sum, e[W], e[W-1:0]);
                end
            end
        end
    end

    // Directed vectors with hand-computed {cout,sum}.
    logic [W-1:0] va [10] = '{16'd23444, 16'hFFFF, 16'h8000, 16'h0F0F, 16'h0000,
                              16'hFFFF,  16'h1234, 16'hAAAA, 16'hAAAA, 16'h7FFF};
    logic [W-1:0] vb [10] = '{16'd54433, 16'h0000, 16'h8000, 16'h00F1, 16'h0000,
                              16'hFFFF,  16'h4321, 16'h5555, 16'h5555, 16'h0001};
    logic         vc [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [W:0]   ve [10] = '{{1'b1, 16'd12341}, {1'b1, 16'h0000}, {1'b1, 16'h0000},
                              {1'b0, 16'h1000},  {1'b0, 16'h0000}, {1'b1, 16'hFFFF},
                              {1'b0, 16'h5555},  {1'b0, 16'hFFFF}, {1'b1, 16'h0000},
                              {1'b0, 16'h8000}};

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        rst_n   = 1'b0;
        bus.a   = 16'd23444;
        bus.b   = 16'd54433;
        bus.cin = 1'b1;
        #7;
        check_now("reset_initial", '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) drive(va[i], vb[i], vc[i], ve[i]);
        // Back-to-back operands on consecutive edges.
        drive(16'd1, 16'd2, 1'b0, 17'd3);
        drive(16'd100, 16'd200, 1'b1, 17'd301);
        drain();

        // Mid-stream reset discards the in-flight operands.
        drive(16'd23444, 16'd54433, 1'b0, {1'b1, 16'd12341});
        drain();
        @(negedge clk);
        bus.a   = 16'h00FF;
        bus.b   = 16'h0001;
        bus.cin = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_now("reset_async", '0);
        bus.a = 16'd23444;
        bus.b = 16'd54433;
        @(posedge clk);
        #1;
        check_now("reset_hold", '0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back({1'b1, 16'd12341});
        id_q.push_back(next_id);
        next_id++;
        drain();

        // Reference-model comparison over random operands.
        for (int i = 0; i < 10000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(1, 0));
            drive(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {16'd0, rc});
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cla.md
CLA -- requirements
Module: cla

Interface
REQ-001 Parameter: WIDTH, default 16, operand/sum width; SHALL be a positive multiple of 4.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: a  input  WIDTH  unsigned addend A.
REQ-005 Port: b  input  WIDTH  unsigned addend B.
REQ-006 Port: cin  input  1  carry-in, LSB weight.
REQ-007 Port: sum  output  WIDTH  registered result, {cout,sum} = a + b + cin.
REQ-008 Port: cout  output  1  registered carry-out of bit WIDTH-1.

Function
REQ-009 The block SHALL compute a + b + cin as an unsigned (WIDTH+1)-bit result; sum = low WIDTH bits, cout = bit WIDTH.
REQ-010 Per-bit generate g[i] = a[i]&b[i] and propagate p[i] = a[i]^b[i]; sum[i] = p[i]^c[i]; c[0] = cin.
REQ-011 Carries SHALL be formed by lookahead, not ripple: each 4-bit group derives c[i+1] = g[i] | p[i]&c[i], fully expanded inside the group, plus a group generate G and group propagate P.
REQ-012 Group carries SHALL come from a second-level lookahead over (G,P) of all groups; cout = carry out of the last group.
REQ-013 The adder core SHALL be combinational; sum and cout SHALL be captured in output registers on each rising clk edge.
REQ-014 Latency: exactly 1 cycle; inputs sampled at edge N appear on sum/cout after edge N; new operands accepted every cycle, no handshake.
REQ-015 Wrap-around: overflow beyond WIDTH bits SHALL appear only on cout; sum wraps modulo 2^WIDTH.
REQ-016 Full-propagate chain (a^b all ones) SHALL pass cin to cout within the same combinational evaluation.
REQ-017 No X-propagation from unused logic; outputs SHALL depend only on a, b, cin and reset.

Reset
REQ-018 rst_n low SHALL immediately (asynchronously) force sum = 0 and cout = 0, independent of clk.
REQ-019 While rst_n is low, outputs SHALL hold 0; inputs are ignored.
REQ-020 Reset release SHALL be synchronous-safe: the first rising clk edge with rst_n high captures the current a + b + cin.
REQ-021 Reset asserted mid-stream SHALL discard the in-flight result; no stale value SHALL reappear after release.

Structure
REQ-022 A shared package SHALL hold the WIDTH default (16) and the group size constant (4).
REQ-023 One sub-module cla4 SHALL be used: 4-bit lookahead block with inputs a[3:0], b[3:0], c_in; outputs s[3:0], G, P (no clock).
REQ-024 The top level SHALL instantiate WIDTH/4 cla4 blocks, the second-level carry lookahead, and the output register.

Verification
REQ-025 a=23444, b=54433, cin=0, one clk edge -> sum=12341, cout=1.
REQ-026 a=16'hFFFF, b=16'h0000, cin=1 -> sum=0, cout=1 (full propagate chain).
REQ-027 a=16'h8000, b=16'h8000, cin=0 -> sum=0, cout=1; a=16'h0F0F, b=16'h00F1, cin=0 -> sum=16'h1000, cout=0.
REQ-028 Back-to-back operands on consecutive edges (1+2+0, then 100+200+1) -> sum 3 then 301, each one cycle after sampling, cout=0.
REQ-029 Drive a=23444, b=54433; assert rst_n low between edges -> sum=0, cout=0 immediately; release -> next edge sum=12341, cout=1.
REQ-030 Randomized operands (>=10000) SHALL match a reference a+b+cin model on {cout,sum} with 1-cycle delay.
